alarm_clock_fsm: RTL and testbench
==================================

// Module: alarm_clock_fsm
// PURPOSE
//   Main control FSM of the digital alarm clock. Decodes keypad digits and the ALARM/TIME
//   buttons, sequences digit entry into the key shift register, and issues load strobes
//   for the new alarm/current time. Drives reset_count into the timing generator when a
//   new current time is loaded. Uses one_second from the timing generator for the entry timeout.
// PARAMETERS
//   TIMEOUT_SEC  10     one_second pulses with no key activity before entry is abandoned (>=2)
//   NOKEY        4'hA   key code meaning "no key pressed"
// PORTS
//   clock          in   1  system clock (256 Hz, shared with timing generator)
//   reset_n        in   1  asynchronous, active-low reset
//   one_second     in   1  one-cycle pulse per second from timing generator
//   key            in   4  keypad code: 0-9 digit, NOKEY idle, 4'hB-4'hF treated as NOKEY
//   alarm_button   in   1  ALARM button, level, high while held
//   time_button    in   1  TIME button, level, high while held
//   shift          out  1  one-cycle pulse: shift current digit into key register
//   load_new_a     out  1  one-cycle pulse: load key register into alarm-time register
//   load_new_c     out  1  one-cycle pulse: load key register into current-time counter
//   reset_count    out  1  one-cycle pulse coincident with load_new_c; clears timing generator
//   show_a         out  1  level: display alarm time
//   show_new_time  out  1  level: display key register instead of current time
// BEHAVIOUR
//   - Digit = key in 0..9. All outputs registered; they change only on the clock edge that
//     enters the state whose decode they reflect. reset_n low -> state SHOW_TIME, every output 0,
//     timeout counter 0, effective on assertion with no clock edge needed.
//   - States and transitions (evaluated each rising edge):
//     SHOW_TIME : alarm_button -> SHOW_ALARM; else digit -> KEY_STORED; else stay.
//     SHOW_ALARM: show_a=1. Stay while alarm_button=1; on release -> SHOW_TIME.
//     KEY_STORED: shift=1 for exactly this one cycle; unconditionally -> KEY_WAITED.
//     KEY_WAITED: show_new_time=1. key==NOKEY -> KEY_ENTRY; timeout -> SHOW_TIME; else stay.
//     KEY_ENTRY : show_new_time=1. Priority time_button > alarm_button > digit > timeout:
//                 time_button  -> SHOW_TIME, load_new_c=1 and reset_count=1 for one cycle;
//                 alarm_button -> SHOW_TIME, load_new_a=1 for one cycle;
//                 digit        -> KEY_STORED; timeout -> SHOW_TIME; else stay.
//   - A held key produces one shift only; the next shift requires passing through NOKEY.
//   - Buttons pressed in KEY_WAITED (key still held) are ignored.
//   - Latency: key/button sampled at edge N -> strobe high in cycle N..N+1, low after edge N+1.
//   - Button-triggered exit wins over timeout in the same cycle; no load strobe on timeout.
//   - Timeout counter: width $clog2(TIMEOUT_SEC+1). Cleared on entering KEY_STORED and
//     whenever state is not KEY_WAITED/KEY_ENTRY. In KEY_WAITED/KEY_ENTRY increments on
//     one_second. Timeout = one_second high while count == TIMEOUT_SEC-1. Never wraps.
//   - load_new_a and load_new_c never assert together; shift never asserts with either.
//   - reset_n asserted mid-entry abandons entry; no strobe is emitted.
// CONFIGURATION
//   ENTRY_TIMEOUT_EN defined  : timeout counter and the timeout transitions exist as above.
//   ENTRY_TIMEOUT_EN undefined: counter removed. KEY_WAITED/KEY_ENTRY exit only via
//                               key/buttons; one_second is unused.
// TESTING
//   1 reset_n=0 mid KEY_ENTRY -> all outputs 0 immediately; state SHOW_TIME after release.
//   2 key 1,NOKEY,2,NOKEY,3,NOKEY,4,NOKEY, then time_button -> 4 single-cycle shift pulses,
//     show_new_time=1 throughout; one cycle of load_new_c=reset_count=1; show_new_time=0 next.
//   3 key=7 held 20 cycles -> exactly one shift pulse; release, alarm_button -> load_new_a 1 cycle.
//   4 SHOW_TIME, alarm_button held 5 cycles -> show_a=1 from edge after press to edge after release.
//   5 ENTRY_TIMEOUT_EN, TIMEOUT_SEC=10: one digit, then 10 one_second pulses -> SHOW_TIME on the
//     10th, no load strobe; with 9 pulses then time_button -> load_new_c asserted.
//   6 KEY_ENTRY: time_button and alarm_button same cycle -> load_new_c only; undefined macro:
//     40 one_second pulses -> still KEY_ENTRY.

Source files
------------

// File: rtl/alarm_clock_fsm_if.sv
// alarm_clock_fsm_if: keypad/button inputs and strobe/display outputs of the alarm clock control FSM
//   key, alarm_button, time_button, one_second : stimulus into the FSM
//   shift, load_new_a, load_new_c, reset_count : one-cycle strobes out of the FSM
//   show_a, show_new_time                      : display select levels out of the FSM
interface alarm_clock_fsm_if;
    logic [3:0] key;
    logic       one_second;
    logic       alarm_button;
    logic       time_button;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;
    logic       reset_count;
    logic       show_a;
    logic       show_new_time;
    modport master (
        output key, one_second, alarm_button, time_button,
        input  shift, load_new_a, load_new_c, reset_count, show_a, show_new_time
    );
    modport slave (
        input  key, one_second, alarm_button, time_button,
        output shift, load_new_a, load_new_c, reset_count, show_a, show_new_time
    );
endinterface

// File: rtl/alarm_clock_fsm.sv
// alarm_clock_fsm: digit entry sequencing and alarm/current-time load strobes for the alarm clock
//   clock   : system clock shared with the timing generator
//   reset_n : asynchronous active-low reset
//   bus     : alarm_clock_fsm_if.slave (keypad, buttons, one_second in; strobes and display selects out)
//   ENTRY_TIMEOUT_EN : when defined, an idle entry is abandoned after TIMEOUT_SEC one_second pulses
module alarm_clock_fsm #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NOKEY       = 4'hA
) (
    input logic          clock,
    input logic          reset_n,
    alarm_clock_fsm_if.slave bus
);
    typedef enum logic [2:0] {SHOW_TIME, SHOW_ALARM, KEY_STORED, KEY_WAITED, KEY_ENTRY} state_t;
    state_t state_q, state_d;
    logic   shift_q, shift_d, load_new_a_q, load_new_a_d, load_new_c_q, load_new_c_d;
    logic   show_a_q, show_a_d, show_new_time_q, show_new_time_d;
    logic   digit, no_key, in_entry, timeout;
    assign digit    = bus.key <= 4'd9;
    assign no_key   = bus.key == NOKEY || bus.key > 4'd9;
    assign in_entry = state_q == KEY_WAITED || state_q == KEY_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_SEC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timeout = bus.one_second && cnt_q == CW'(TIMEOUT_SEC - 1);
    // Saturates rather than wraps; a new digit restarts the idle window.
    always_comb begin
        cnt_d = (!in_entry || state_d == KEY_STORED) ? '0 :
                (bus.one_second && cnt_q != CW'(TIMEOUT_SEC)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_one_second;
    assign unused_one_second = bus.one_second;
    assign timeout           = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME:  state_d = bus.alarm_button ? SHOW_ALARM : digit ? KEY_STORED : SHOW_TIME;
            SHOW_ALARM: state_d = bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
            KEY_STORED: state_d = KEY_WAITED;
            KEY_WAITED: state_d = no_key ? KEY_ENTRY : timeout ? SHOW_TIME : KEY_WAITED;
            KEY_ENTRY:  state_d = (bus.time_button || bus.alarm_button) ? SHOW_TIME :
                                  digit ? KEY_STORED : timeout ? SHOW_TIME : KEY_ENTRY;
            default:    state_d = SHOW_TIME;
        endcase
        // Outputs decode the state being entered so they appear registered with no extra cycle.
        shift_d         = state_d == KEY_STORED;
        show_a_d        = state_d == SHOW_ALARM;
        show_new_time_d = state_d == KEY_STORED || state_d == KEY_WAITED || state_d == KEY_ENTRY;
        load_new_c_d    = state_q == KEY_ENTRY && bus.time_button;
        load_new_a_d    = state_q == KEY_ENTRY && !bus.time_button && bus.alarm_button;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= SHOW_TIME;
            shift_q         <= 1'b0;
            load_new_a_q    <= 1'b0;
            load_new_c_q    <= 1'b0;
            show_a_q        <= 1'b0;
            show_new_time_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            load_new_a_q    <= load_new_a_d;
            load_new_c_q    <= load_new_c_d;
            show_a_q        <= show_a_d;
            show_new_time_q <= show_new_time_d;
        end
    end
    assign bus.shift         = shift_q;
    assign bus.load_new_a    = load_new_a_q;
    assign bus.load_new_c    = load_new_c_q;
    assign bus.reset_count   = load_new_c_q;
    assign bus.show_a        = show_a_q;
    assign bus.show_new_time = show_new_time_q;
endmodule

// File: tb/tb_alarm_clock_fsm.sv
// tb_alarm_clock_fsm: scoreboard bench for alarm_clock_fsm; output vector {shift,load_a,load_c,reset_count,show_a,show_new}
module tb_alarm_clock_fsm;
    localparam logic [3:0] NK = 4'hA;
    localparam logic [5:0] E0 = 6'b000000;
    localparam logic [5:0] SH = 6'b100001;
    localparam logic [5:0] NT = 6'b000001;
    localparam logic [5:0] LA = 6'b010000;
    localparam logic [5:0] LC = 6'b001100;
    localparam logic [5:0] SA = 6'b000010;
    typedef struct {
        logic [3:0] k;
        logic       ab;
        logic       tbt;
        logic       os;
        logic [5:0] exp;
    } step_t;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    step_t      stim[$];
    logic [5:0] sb[$];
    logic [5:0] outs;
    logic [5:0] exp;
    alarm_clock_fsm_if bus ();
    alarm_clock_fsm #(.TIMEOUT_SEC(10), .NOKEY(4'hA)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    assign outs = {bus.shift, bus.load_new_a, bus.load_new_c, bus.reset_count, bus.show_a, bus.show_new_time};
    task automatic add(input logic [3:0] k, input logic ab, input logic tbt, input logic os, input logic [5:0] e);
        stim.push_back('{k, ab, tbt, os, e});
    endtask
    task automatic apply();
        step_t s;
        s = stim.pop_front();
        @(negedge clock);
        bus.key = s.k;
        bus.alarm_button = s.ab;
        bus.time_button = s.tbt;
        bus.one_second = s.os;
        sb.push_back(s.exp);
        @(posedge clock);
        #1;
    endtask
    task automatic test_reset();
        reset_n = 1'b0;
        bus.key = NK;
        bus.alarm_button = 1'b0;
        bus.time_button = 1'b0;
        bus.one_second = 1'b0;
        #3;
        sb.push_back(E0);
        exp = sb.pop_front();
        checks++;
        if (outs !== exp) begin failures++; $display("FAIL reset got=%b exp=%b", outs, exp); end
        @(negedge clock);
        reset_n = 1'b1;
        add(NK, 0, 0, 0, E0);
        add(NK, 0, 1, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL reset_idle cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
    task automatic test_entry();
        add(4'd1, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        add(4'd2, 0, 0, 0, SH); add(4'hF, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        add(4'd3, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        add(4'd4, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        add(NK, 0, 1, 0, LC); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL entry cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
    task automatic test_held_key();
        add(4'd7, 0, 0, 0, SH);
        for (int i = 0; i < 19; i++) add(4'd7, i == 5, i == 9, 0, NT);
        add(NK, 0, 0, 0, NT); add(NK, 1, 0, 0, LA); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL held_key cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
    task automatic test_show_alarm();
        for (int i = 0; i < 5; i++) add(i == 2 ? 4'd5 : NK, 1, 0, 0, SA);
        add(NK, 0, 0, 0, E0); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL show_alarm cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
    task automatic test_both_buttons();
        add(4'd3, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        add(NK, 1, 1, 0, LC); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL both_buttons cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
`ifdef ENTRY_TIMEOUT_EN
    task automatic test_timeout();
        add(4'd3, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        for (int i = 0; i < 9; i++) begin add(NK, 0, 0, 1, NT); add(NK, 0, 0, 0, NT); end
        add(NK, 0, 0, 1, E0); add(NK, 0, 0, 0, E0);
        add(4'd3, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        for (int i = 0; i < 9; i++) begin add(NK, 0, 0, 1, NT); add(NK, 0, 0, 0, NT); end
        add(NK, 0, 1, 1, LC); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL timeout cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
`else
    task automatic test_no_timeout();
        add(4'd3, 0, 0, 0, SH); add(NK, 0, 0, 1, NT);
        for (int i = 0; i < 40; i++) add(NK, 0, 0, 1, NT);
        add(NK, 0, 1, 0, LC); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL no_timeout cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
`endif
    task automatic test_reset_mid_entry();
        add(4'd5, 0, 0, 0, SH); add(NK, 0, 0, 0, NT); add(NK, 0, 0, 0, NT);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL mid_reset_pre cyc%0d got=%b exp=%b", c, outs, exp); end
        end
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        bus.time_button = 1'b1;
        #1;
        sb.push_back(E0);
        exp = sb.pop_front();
        checks++;
        if (outs !== exp) begin failures++; $display("FAIL mid_reset_async got=%b exp=%b", outs, exp); end
        @(negedge clock);
        reset_n = 1'b1;
        add(NK, 0, 1, 0, E0); add(NK, 1, 0, 0, SA); add(NK, 0, 0, 0, E0);
        for (int c = 0; stim.size() > 0; c++) begin
            apply();
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin failures++; $display("FAIL mid_reset_post cyc%0d got=%b exp=%b", c, outs, exp); end
        end
    endtask
    initial begin
        test_reset();
        test_entry();
        test_held_key();
        test_show_alarm();
        test_both_buttons();
`ifdef ENTRY_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_entry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
